// File: rtl/btn_preset_debouncer_pkg.sv
// Shared encodings and defaults for the button preset debouncer.
// Optional auto-repeat is selected with the AUTO_REPEAT_EN macro.
package btn_preset_debouncer_pkg;

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] PRESS_CHK   = 2'd1;
  localparam logic [1:0] HELD        = 2'd2;
  localparam logic [1:0] RELEASE_CHK = 2'd3;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_REPEAT_CYCLES   = 64;

endpackage

// File: rtl/btn_preset_debouncer_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; shared by other button inputs.
module sync_2ff (
  input  logic clk,
  input  logic reset_btn,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk) begin
    if (reset_btn) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/btn_preset_debouncer.sv
// Debounces a raw push-button into a one-cycle preset pulse plus captured switch value.
// Define AUTO_REPEAT_EN to emit repeat pulses every REPEAT_CYCLES while held.
module btn_preset_debouncer
  import btn_preset_debouncer_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic             clk,
  input  logic             reset_btn,
  input  logic             btn_raw,
  input  logic [WIDTH-1:0] sw_value,
  output logic             preset_pulse,
  output logic [WIDTH-1:0] load_value,
  output logic             btn_level
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be >= 2");
  end
  if (REPEAT_CYCLES < 2) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be >= 2");
  end

  logic          btn_s;
  logic [1:0]    state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          press_fire, rep_fire, fire;

  sync_2ff u_sync (
    .clk      (clk),
    .reset_btn(reset_btn),
    .d        (btn_raw),
    .q        (btn_s)
  );

`ifdef AUTO_REPEAT_EN
  localparam int            RW       = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rep, rep_nxt;

  // Only advances while staying in HELD; every other path returns it to zero.
  always_comb begin
    rep_fire = (state == HELD) && btn_s && (rep == REP_LAST);
    rep_nxt  = '0;
    if (state == HELD && btn_s && !rep_fire) rep_nxt = rep + RW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset_btn) rep <= '0;
    else           rep <= rep_nxt;
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset_btn) begin
      state        <= IDLE;
      cnt          <= '0;
      preset_pulse <= 1'b0;
      load_value   <= '0;
    end else begin
      state        <= nxt;
      cnt          <= cnt_nxt;
      preset_pulse <= fire;
      if (fire) load_value <= sw_value;
    end
  end

  always_comb begin
    nxt        = state;
    press_fire = 1'b0;
    case (state)
      IDLE:        if (btn_s) nxt = PRESS_CHK;
      PRESS_CHK:   if (!btn_s) nxt = IDLE;
                   else if (cnt == CNT_LAST) begin
                     nxt        = HELD;
                     press_fire = 1'b1;
                   end
      HELD:        if (!btn_s) nxt = RELEASE_CHK;
      RELEASE_CHK: if (btn_s) nxt = HELD;
                   else if (cnt == CNT_LAST) nxt = IDLE;
      default:     nxt = IDLE;
    endcase
    // Cleared on every state entry; staying in a check state implies cnt < CNT_LAST.
    cnt_nxt = '0;
    if (nxt == state && (state == PRESS_CHK || state == RELEASE_CHK))
      cnt_nxt = cnt + CW'(1);
  end

  always_comb begin
    fire      = press_fire | rep_fire;
    btn_level = (state == HELD) || (state == RELEASE_CHK);
  end

endmodule

// File: tb/tb_btn_preset_debouncer.sv
// Scoreboard bench: run-length reference model predicts pulses; a negedge monitor checks them.
module tb_btn_preset_debouncer;

  localparam int D = 4;
  localparam int R = 8;

  logic       clk = 1'b0;
  logic       reset_btn;
  logic       btn_raw;
  logic [7:0] sw_value;
  logic       preset_pulse;
  logic [7:0] load_value;
  logic       btn_level;

  int checks   = 0;
  int failures = 0;

  btn_preset_debouncer #(.WIDTH(8), .DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
    .clk         (clk),
    .reset_btn   (reset_btn),
    .btn_raw     (btn_raw),
    .sw_value    (sw_value),
    .preset_pulse(preset_pulse),
    .load_value  (load_value),
    .btn_level   (btn_level)
  );

  always #5 clk = ~clk;

  typedef struct { int edge_no; logic [7:0] val; } exp_t;
  exp_t q[$];

  // Reference model state
  int         edge_no = 0;
  bit         m_s1, m_s2, m_pressed;
  int         ones, zeros, rep;
  logic [7:0] exp_load;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  // Accept a press after D+1 consecutive synchronised highs, a release after D+1 lows.
  always @(posedge clk) begin
    bit x, fire;
    edge_no++;
    fire = 1'b0;
    if (reset_btn) begin
      m_s1 = 0; m_s2 = 0; m_pressed = 0;
      ones = 0; zeros = 0; rep = 0; exp_load = 8'h00;
    end else begin
      x    = m_s2;
      m_s2 = m_s1;
      m_s1 = btn_raw;
      if (!m_pressed) begin
        ones = x ? ones + 1 : 0;
        if (ones == D + 1) begin
          m_pressed = 1; zeros = 0; rep = 0; fire = 1'b1;
        end
      end else if (x) begin
        if (zeros == 0) begin
`ifdef AUTO_REPEAT_EN
          rep++;
          if (rep == R) begin rep = 0; fire = 1'b1; end
`endif
        end else begin
          zeros = 0; rep = 0;
        end
      end else begin
        zeros++; rep = 0;
        if (zeros == D + 1) begin m_pressed = 0; ones = 0; end
      end
      if (fire) begin
        exp_load = sw_value;
        q.push_back('{edge_no, sw_value});
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (edge_no > 0) begin
      if (preset_pulse === 1'b1) begin
        if (q.size() == 0) chk("spurious_pulse", 32'(preset_pulse), 32'd0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("pulse_edge", edge_no, e.edge_no);
          chk("pulse_load", 32'(load_value), 32'(e.val));
        end
      end else if (q.size() > 0 && q[0].edge_no <= edge_no) begin
        void'(q.pop_front());
        chk("missed_pulse", 32'(preset_pulse), 32'd1);
      end
      chk("load_value", 32'(load_value), 32'(exp_load));
      chk("btn_level", 32'(btn_level), 32'(m_pressed));
    end
  end

  task automatic drive(input logic v, input int n);
    btn_raw = v;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int got, nb;
    btn_raw = 1'b0; sw_value = 8'h00; reset_btn = 1'b1;
    repeat (2) @(negedge clk);

    // Reset with the button held: outputs stay clear, then full qualification.
    btn_raw = 1'b1; sw_value = 8'hFF;
    repeat (2) @(negedge clk);
    chk("reset_pulse", 32'(preset_pulse), 32'd0);
    chk("reset_load", 32'(load_value), 32'h00);
    chk("reset_level", 32'(btn_level), 32'd0);
    reset_btn = 1'b0;
    got = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (preset_pulse === 1'b1) begin got = k; break; end
    end
    chk("post_reset_latency", got, 7);
    drive(1, 6);
    drive(0, 10);

    // Clean press
    sw_value = 8'hAA;
    got = 0;
    btn_raw = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (preset_pulse === 1'b1) begin got = k; break; end
    end
    chk("clean_press_latency", got, 7);
    chk("clean_press_load", 32'(load_value), 32'hAA);
    drive(1, 12);
    drive(0, 10);

    // Press bounce
    sw_value = 8'h5C;
    drive(1, 1); drive(0, 1); drive(1, 1); drive(0, 1);
    drive(1, 15);

    // Release bounce, then a stable release
    drive(0, 2);
    drive(1, 5);
    chk("release_bounce_level", 32'(btn_level), 32'd1);
    drive(0, 10);
    chk("released_level", 32'(btn_level), 32'd0);

    // Mid-press reset
    drive(0, 2);
    reset_btn = 1'b1; drive(0, 1); reset_btn = 1'b0;
    sw_value = 8'h77;
    drive(1, 5);
    reset_btn = 1'b1; drive(1, 2); reset_btn = 1'b0;
    chk("mid_reset_load", 32'(load_value), 32'h00);
    chk("mid_reset_level", 32'(btn_level), 32'd0);
    drive(0, 10);

    // Long hold with changing switches (repeat pulses when enabled)
    sw_value = 8'h01;
    drive(1, 15);
    sw_value = 8'h02;
    drive(1, 25);
    drive(0, 10);

    // Randomised bouncing presses, holds, releases and resets
    for (int it = 0; it < 40; it++) begin
      sw_value = 8'($urandom);
      nb = $urandom_range(0, 3);
      for (int b = 0; b < nb; b++) begin
        drive(1, $urandom_range(1, 3));
        drive(0, $urandom_range(1, 3));
      end
      if ($urandom_range(0, 4) == 0) begin
        drive(1, $urandom_range(2, 6));
        reset_btn = 1'b1;
        drive(btn_raw, $urandom_range(1, 2));
        reset_btn = 1'b0;
        drive(0, 8);
        continue;
      end
      drive(1, $urandom_range(1, 20));
      sw_value = 8'($urandom);
      drive(1, $urandom_range(1, 20));
      nb = $urandom_range(0, 2);
      for (int b = 0; b < nb; b++) begin
        drive(0, $urandom_range(1, 3));
        drive(1, $urandom_range(1, 3));
      end
      drive(0, $urandom_range(3, 12));
    end

    drive(0, 12);
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
